// File: rtl/jtcomsc_pcm_cache_pkg.sv
// Shared definitions for the Combat School PCM line cache: line geometry,
// FSM state encoding and the byte-select helper used by each line.
package jtcomsc_pcm_cache_pkg;

    localparam int LW = 2;          // log2 bytes per line
    localparam int DW = 8 << LW;    // line width in bits

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_PREF = 2'd2;

    function automatic logic [7:0] sel_byte(input logic [DW-1:0] word,
                                            input logic [LW-1:0] bsel);
        return word[{bsel, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/jtcomsc_pcm_line.sv
// One cache line: tag, data word and valid flag, with lookup compare and
// little-endian byte selection.
module jtcomsc_pcm_line
    import jtcomsc_pcm_cache_pkg::*;
#(
    parameter int TW = 15
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_inval,
    input  logic          i_load,
    input  logic [TW-1:0] i_ld_tag,
    input  logic [DW-1:0] i_ld_data,
    input  logic [TW-1:0] i_tag,
    input  logic [LW-1:0] i_bsel,
    output logic          o_hit,
    output logic [7:0]    o_byte,
    output logic [TW-1:0] o_tag,
    output logic [DW-1:0] o_data,
    output logic          o_valid
);

    logic [TW-1:0] r_tag;
    logic [DW-1:0] r_data;
    logic          r_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (i_load) begin
                r_tag  <= i_ld_tag;
                r_data <= i_ld_data;
            end
            // Invalidation wins so a download never leaves a line marked valid.
            if (i_inval)
                r_valid <= 1'b0;
            else if (i_load)
                r_valid <= 1'b1;
        end
    end

    assign o_hit   = r_valid && (r_tag == i_tag);
    assign o_byte  = sel_byte(r_data, i_bsel);
    assign o_tag   = r_tag;
    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/jtcomsc_pcm_cache.sv
// Two-line PCM ROM cache between the uPD7759 byte port and the SDRAM word
// channel: an active line plus a prefetched successor line.
module jtcomsc_pcm_cache
    import jtcomsc_pcm_cache_pkg::*;
#(
    parameter int AW = 17
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          dwnld,
    input  logic          pcm_cs,
    input  logic [AW-1:0] pcm_addr,
    output logic [7:0]    pcm_data,
    output logic          pcm_ok,
    output logic [AW-3:0] sdram_addr,
    output logic          sdram_req,
    input  logic          sdram_rdy,
    input  logic [31:0]   sdram_data
);

    localparam int            TW      = AW - LW;
    localparam logic [TW-1:0] TAG_ONE = TW'(1);

    logic [TW-1:0] w_tag;
    logic [LW-1:0] w_bsel;
    logic          w_line0_hit, w_line1_hit;
    logic          w_v0, w_v1;
    logic          w_hit0;
    logic [7:0]    w_byte0, w_byte1;
    logic [TW-1:0] w_tag0, w_tag1;
    logic [DW-1:0] w_data0, w_data1;
    logic          w_promote, w_fill_done, w_pref_done;
    logic          w_ld0;
    logic [TW-1:0] w_ld0_tag;
    logic [DW-1:0] w_ld0_data;
    logic          w_inval1;
    logic          w_idle_pref;
    logic          w_unused;

    logic [1:0]    r_state;
    logic [TW-1:0] r_sdram_addr;
    logic          r_sdram_req;
    logic          r_ok;
    logic [7:0]    r_data;
    logic [AW-1:0] r_addr_q;

    assign w_tag  = pcm_addr[AW-1:LW];
    assign w_bsel = pcm_addr[LW-1:0];
    assign w_hit0 = pcm_cs && w_line0_hit;

    // Idle prefetch keeps line1 primed behind the active line between reads.
    assign w_idle_pref = !pcm_cs && w_v0 && !w_v1;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case leaves it unassigned and infers a latch.
        w_promote   = 1'b0;
        w_fill_done = 1'b0;
        w_pref_done = 1'b0;
        case (r_state)
            ST_IDLE: w_promote   = !dwnld && pcm_cs && !w_line0_hit && w_line1_hit;
            ST_FILL: w_fill_done = sdram_rdy && !dwnld;
            ST_PREF: w_pref_done = sdram_rdy && !dwnld;
            default: ;
        endcase
    end

    assign w_ld0      = w_promote || w_fill_done;
    assign w_ld0_tag  = w_promote ? w_tag1  : r_sdram_addr;
    assign w_ld0_data = w_promote ? w_data1 : sdram_data;
    assign w_inval1   = dwnld || w_promote;

    jtcomsc_pcm_line #(.TW(TW)) u_line0 (
        .clk       (clk),
        .rst       (rst),
        .i_inval   (dwnld),
        .i_load    (w_ld0),
        .i_ld_tag  (w_ld0_tag),
        .i_ld_data (w_ld0_data),
        .i_tag     (w_tag),
        .i_bsel    (w_bsel),
        .o_hit     (w_line0_hit),
        .o_byte    (w_byte0),
        .o_tag     (w_tag0),
        .o_data    (w_data0),
        .o_valid   (w_v0)
    );

    jtcomsc_pcm_line #(.TW(TW)) u_line1 (
        .clk       (clk),
        .rst       (rst),
        .i_inval   (w_inval1),
        .i_load    (w_pref_done),
        .i_ld_tag  (r_sdram_addr),
        .i_ld_data (sdram_data),
        .i_tag     (w_tag),
        .i_bsel    (w_bsel),
        .o_hit     (w_line1_hit),
        .o_byte    (w_byte1),
        .o_tag     (w_tag1),
        .o_data    (w_data1),
        .o_valid   (w_v1)
    );

    // Line1's byte port and line0's data word have no consumer here.
    assign w_unused = ^{w_byte1, w_data0};

    // A request, once raised, holds address and req until sdram_rdy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_sdram_addr <= '0;
            r_sdram_req  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!dwnld) begin
                        if (pcm_cs && !w_hit0) begin
                            r_sdram_req <= 1'b1;
                            if (w_promote) begin
                                r_state      <= ST_PREF;
                                r_sdram_addr <= w_tag + TAG_ONE;
                            end else begin
                                r_state      <= ST_FILL;
                                r_sdram_addr <= w_tag;
                            end
                        end else if (w_idle_pref) begin
                            r_state      <= ST_PREF;
                            r_sdram_addr <= w_tag0 + TAG_ONE;
                            r_sdram_req  <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    if (sdram_rdy) begin
                        if (dwnld) begin
                            r_state     <= ST_IDLE;
                            r_sdram_req <= 1'b0;
                        end else begin
                            r_state      <= ST_PREF;
                            r_sdram_addr <= r_sdram_addr + TAG_ONE;
                        end
                    end
                end
                ST_PREF: begin
                    if (sdram_rdy) begin
                        r_state     <= ST_IDLE;
                        r_sdram_req <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_sdram_req <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ok     <= 1'b0;
            r_data   <= '0;
            r_addr_q <= '0;
        end else begin
            r_ok <= w_hit0 && !dwnld;
            if (w_hit0) begin
                r_data   <= w_byte0;
                r_addr_q <= pcm_addr;
            end
        end
    end

    // The address compare drops pcm_ok in the same cycle the decoder moves on.
    assign pcm_ok     = r_ok && pcm_cs && (pcm_addr == r_addr_q);
    assign pcm_data   = r_data;
    assign sdram_addr = r_sdram_addr;
    assign sdram_req  = r_sdram_req;

endmodule

// File: tb/tb_jtcomsc_pcm_cache.sv
// Self-checking bench for jtcomsc_pcm_cache: a behavioural SDRAM responder
// with programmable latency and a ROM content function as the reference.
module tb_jtcomsc_pcm_cache;

    localparam int AW = 17;

    logic          clk;
    logic          rst;
    logic          dwnld;
    logic          pcm_cs;
    logic [AW-1:0] pcm_addr;
    logic [7:0]    pcm_data;
    logic          pcm_ok;
    logic [AW-3:0] sdram_addr;
    logic          sdram_req;
    logic          sdram_rdy;
    logic [31:0]   sdram_data;

    int checks = 0;
    int errors = 0;
    int lat_cfg = 3;
    int stray_want = 0;
    logic [AW-3:0] req_log[$];

    jtcomsc_pcm_cache #(.AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .dwnld      (dwnld),
        .pcm_cs     (pcm_cs),
        .pcm_addr   (pcm_addr),
        .pcm_data   (pcm_data),
        .pcm_ok     (pcm_ok),
        .sdram_addr (sdram_addr),
        .sdram_req  (sdram_req),
        .sdram_rdy  (sdram_rdy),
        .sdram_data (sdram_data)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // ROM contents: word 1 is fixed for the cold-read scenario, the rest hashed.
    function automatic logic [31:0] mem_word(input logic [AW-3:0] w);
        if (w == 15'h0001)
            return 32'hDDCCBBAA;
        return (32'(w) * 32'h9E3779B1) ^ 32'h13572468;
    endfunction

    function automatic logic [7:0] exp_byte(input logic [AW-1:0] a);
        logic [31:0] wd;
        wd = mem_word(a[AW-1:2]);
        return 8'(wd >> (8 * int'(a[1:0])));
    endfunction

    // SDRAM responder: rdy after lat_cfg cycles of a held request.
    initial begin : sdram_model
        int k;
        int stray_done;
        k = 0;
        stray_done = 0;
        sdram_rdy  = 1'b0;
        sdram_data = '0;
        forever begin
            @(negedge clk);
            sdram_rdy = 1'b0;
            if (stray_want != stray_done) begin
                stray_done++;
                sdram_rdy  = 1'b1;
                sdram_data = 32'hFFFF_FFFF;
                k = 0;
            end else if (rst || !sdram_req) begin
                k = 0;
            end else begin
                k++;
                if (k >= lat_cfg) begin
                    sdram_rdy  = 1'b1;
                    sdram_data = mem_word(sdram_addr);
                    req_log.push_back(sdram_addr);
                    k = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation still running, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        pcm_cs = 1'b0;
        dwnld = 1'b0;
        pcm_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Present an address and wait (bounded) for pcm_ok; lat counts edges.
    task automatic read_byte(input logic [AW-1:0] a, output logic [7:0] d,
                             output int lat, output bit got);
        @(posedge clk);
        #1;
        pcm_cs = 1'b1;
        pcm_addr = a;
        got = 1'b0;
        lat = -1;
        d = '0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (pcm_ok) begin
                got = 1'b1;
                lat = i;
                d = pcm_data;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (!sdram_req) begin
                idle = 1'b1;
                break;
            end
        end
        checks++;
        if (!idle) begin
            errors++;
            $display("FAIL %s_idle: sdram_req=%0b want 0 within 300 cycles", name, sdram_req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pcm_cs = 1'b0;
        dwnld = 1'b0;
        pcm_addr = '0;
        do_reset();
        tick();
        checks++;
        if (pcm_ok !== 1'b0) begin errors++; $display("FAIL reset_ok: got %0b want 0", pcm_ok); end
        checks++;
        if (pcm_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h want 00", pcm_data); end
        checks++;
        if (sdram_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", sdram_req); end
        checks++;
        if (sdram_addr !== '0) begin errors++; $display("FAIL reset_addr: got %04h want 0000", sdram_addr); end
    endtask

    task automatic test_cold_read();
        int base;
        bit early_ok;
        bit fired;
        lat_cfg = 4;
        base = req_log.size();
        @(posedge clk);
        #1;
        pcm_cs = 1'b1;
        pcm_addr = 17'h00005;
        tick();
        checks++;
        if (sdram_req !== 1'b0) begin errors++; $display("FAIL cold_req_n: got %0b want 0", sdram_req); end
        tick();
        checks++;
        if (sdram_req !== 1'b1 || sdram_addr !== 15'h0001) begin
            errors++;
            $display("FAIL cold_fill_req: req=%0b addr=%04h want 1/0001", sdram_req, sdram_addr);
        end
        early_ok = 1'b0;
        fired = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (pcm_ok) early_ok = 1'b1;
            if (req_log.size() > base) begin fired = 1'b1; break; end
            tick();
        end
        checks++;
        if (!fired || early_ok) begin
            errors++;
            $display("FAIL cold_fill_wait: rdy_seen=%0b early_ok=%0b want 1/0", fired, early_ok);
        end
        checks++;
        if (req_log.size() < base + 1 || req_log[base] !== 15'h0001) begin
            errors++;
            $display("FAIL cold_fill_addr: got %0d entries want first 0001", req_log.size() - base);
        end
        tick();
        checks++;
        if (sdram_req !== 1'b1 || sdram_addr !== 15'h0002 || pcm_ok !== 1'b0) begin
            errors++;
            $display("FAIL cold_pref_start: req=%0b addr=%04h ok=%0b want 1/0002/0", sdram_req, sdram_addr, pcm_ok);
        end
        tick();
        checks++;
        if (pcm_ok !== 1'b1 || pcm_data !== 8'hBB) begin
            errors++;
            $display("FAIL cold_data: ok=%0b data=%02h want 1/BB", pcm_ok, pcm_data);
        end
        wait_idle("cold");
    endtask

    task automatic test_sequential();
        int base;
        logic [7:0] d;
        int lat;
        bit got;
        lat_cfg = 3;
        base = req_log.size();
        for (int a = 4; a <= 11; a++) begin
            read_byte(AW'(a), d, lat, got);
            checks++;
            if (!got || d !== exp_byte(AW'(a)) || lat != ((a == 8) ? 2 : 1)) begin
                errors++;
                $display("FAIL seq_read_%0h: ok=%0b data=%02h lat=%0d want 1/%02h/%0d",
                         a, got, d, lat, exp_byte(AW'(a)), (a == 8) ? 2 : 1);
            end
        end
        wait_idle("seq");
        checks++;
        if (req_log.size() != base + 1 || req_log[base] !== 15'h0003) begin
            errors++;
            $display("FAIL seq_requests: got %0d requests want exactly one PREF 0003", req_log.size() - base);
        end
    endtask

    task automatic test_wrap();
        int base;
        logic [7:0] d;
        int lat;
        bit got;
        do_reset();
        lat_cfg = 3;
        base = req_log.size();
        read_byte(17'h1FFFF, d, lat, got);
        checks++;
        if (!got || d !== exp_byte(17'h1FFFF)) begin
            errors++;
            $display("FAIL wrap_data: ok=%0b data=%02h want 1/%02h", got, d, exp_byte(17'h1FFFF));
        end
        checks++;
        if (req_log.size() < base + 1 || req_log[base] !== 15'h7FFF) begin
            errors++;
            $display("FAIL wrap_fill: got %0d requests want first 7FFF", req_log.size() - base);
        end
        wait_idle("wrap");
        checks++;
        if (req_log.size() != base + 2 || req_log[base+1] !== 15'h0000) begin
            errors++;
            $display("FAIL wrap_pref: got %0d requests want second 0000", req_log.size() - base);
        end
    endtask

    task automatic test_jump_during_pref();
        int base;
        logic [7:0] d;
        int lat;
        bit got;
        do_reset();
        lat_cfg = 6;
        base = req_log.size();
        read_byte(17'h00000, d, lat, got);
        checks++;
        if (!got || d !== exp_byte(17'h00000)) begin
            errors++;
            $display("FAIL jump_first: ok=%0b data=%02h want 1/%02h", got, d, exp_byte(17'h00000));
        end
        read_byte(17'h10000, d, lat, got);
        checks++;
        if (!got || d !== exp_byte(17'h10000)) begin
            errors++;
            $display("FAIL jump_data: ok=%0b data=%02h want 1/%02h", got, d, exp_byte(17'h10000));
        end
        checks++;
        if (req_log.size() < base + 3 || req_log[base+1] !== 15'h0001 || req_log[base+2] !== 15'h4000) begin
            errors++;
            $display("FAIL jump_order: %0d requests done when ok rose, want PREF 0001 then FILL 4000",
                     req_log.size() - base);
        end
        wait_idle("jump");
    endtask

    task automatic test_dwnld();
        int base;
        logic [7:0] d;
        int lat;
        bit got;
        bit quiet;
        do_reset();
        lat_cfg = 3;
        read_byte(17'h00021, d, lat, got);
        wait_idle("dwnld_warm");
        @(posedge clk);
        #1;
        pcm_cs = 1'b0;
        dwnld = 1'b1;
        repeat (4) tick();
        @(posedge clk);
        #1;
        dwnld = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (sdram_req !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin errors++; $display("FAIL dwnld_quiet: sdram_req seen 1 want 0"); end
        base = req_log.size();
        read_byte(17'h00021, d, lat, got);
        checks++;
        if (!got || d !== exp_byte(17'h00021) || lat < 3) begin
            errors++;
            $display("FAIL dwnld_reread: ok=%0b data=%02h lat=%0d want 1/%02h/>=3", got, d, lat, exp_byte(17'h00021));
        end
        checks++;
        if (req_log.size() < base + 1 || req_log[base] !== 15'h0008) begin
            errors++;
            $display("FAIL dwnld_refill: got %0d requests want first 0008", req_log.size() - base);
        end
        wait_idle("dwnld");
    endtask

    task automatic test_reset_mid_request();
        int base;
        logic [7:0] d;
        int lat;
        bit got;
        bit quiet;
        do_reset();
        lat_cfg = 40;
        @(posedge clk);
        #1;
        pcm_cs = 1'b1;
        pcm_addr = 17'h00040;
        tick();
        tick();
        checks++;
        if (sdram_req !== 1'b1) begin errors++; $display("FAIL rstmid_pre: req=%0b want 1", sdram_req); end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (sdram_req !== 1'b0 || pcm_ok !== 1'b0 || sdram_addr !== '0) begin
            errors++;
            $display("FAIL rstmid_drop: req=%0b ok=%0b addr=%04h want 0/0/0000", sdram_req, pcm_ok, sdram_addr);
        end
        pcm_cs = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        stray_want++;
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (sdram_req !== 1'b0 || pcm_ok !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin errors++; $display("FAIL rstmid_stray: req/ok rose after stray rdy, want both 0"); end
        lat_cfg = 3;
        base = req_log.size();
        read_byte(17'h00040, d, lat, got);
        checks++;
        if (!got || d !== exp_byte(17'h00040) || req_log.size() < base + 1 || req_log[base] !== 15'h0010) begin
            errors++;
            $display("FAIL rstmid_read: ok=%0b data=%02h want 1/%02h via FILL 0010", got, d, exp_byte(17'h00040));
        end
        wait_idle("rstmid");
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        logic [AW-1:0] prev;
        logic [7:0] d;
        int lat;
        int mode;
        bit got;
        bit prev_ok;
        do_reset();
        prev = AW'($urandom);
        prev_ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            lat_cfg = $urandom_range(1, 6);
            mode = prev_ok ? int'($urandom_range(0, 3)) : 3;
            case (mode)
                0: a = {prev[AW-1:2], 2'(prev[1:0] + 2'($urandom_range(1, 3)))};
                1: a = prev + AW'(1);
                2: a = prev + AW'(4);
                default: a = AW'($urandom);
            endcase
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
                pcm_cs = 1'b0;
                repeat ($urandom_range(1, 8)) tick();
            end
            read_byte(a, d, lat, got);
            checks++;
            if (!got || d !== exp_byte(a)) begin
                errors++;
                $display("FAIL rand_%0d_data: addr=%05h ok=%0b data=%02h want 1/%02h", n, a, got, d, exp_byte(a));
            end
            if (mode == 0) begin
                checks++;
                if (lat != 1) begin
                    errors++;
                    $display("FAIL rand_%0d_samehit: addr=%05h lat=%0d want 1", n, a, lat);
                end
            end
            prev = a;
            prev_ok = got;
        end
    endtask

    initial begin : main
        test_reset();
        test_cold_read();
        test_sequential();
        test_wrap();
        test_jump_during_pref();
        test_dwnld();
        test_reset_mid_request();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
